uart_rx_core: RTL and testbench

- Serial receive engine inside the AXI4-Lite UART top; sits between the io_rxd pin and the CSR/data-register block.
- Oversamples rxd at 16x the baud rate and deframes start / 8 data / optional parity / stop.
- Presents each received byte in a one-entry holding register with valid/ready.
- Raises parity, framing and overrun status that the register block maps into CSR bits (rx_ok = CSR bit 4).

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_rx_core.sv | 274 +++++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding, CSR bit positions,
// baud divisor constants for the supported system clocks, and small helpers
// used by the receive engine.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  // CSR bit positions
  localparam int unsigned CsrTxOkBit   = 0;
  localparam int unsigned CsrRxOkBit   = 4;
  localparam int unsigned CsrBaudLsb   = 16;
  localparam int unsigned CsrBaudMsb   = 31;

  // Divisors for a 16 MHz system clock
  localparam logic [15:0] Baud16M115200 = 16'h0008;
  localparam logic [15:0] Baud16M9600   = 16'h0067;
  localparam logic [15:0] Baud16M4800   = 16'h00CF;

  // Divisors for a 144 MHz system clock
  localparam logic [15:0] Baud144M115200 = 16'h004D;
  localparam logic [15:0] Baud144M9600   = 16'h03A9;
  localparam logic [15:0] Baud144M4800   = 16'h0752;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Value the parity bit must take for the given data byte.
  function automatic logic parity_bit(input logic [7:0] data, input logic even);
    return even ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator shared by the UART RX and TX cores.
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   en_i       counter runs only while high
//   restart_i  holds the counter at 0 (phase-aligns ticks to a frame start)
//   div_i      tick every div_i+1 clocks
//   tick_o     one-cycle tick pulse
module uart_baud_tick (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        restart_i,
  input  logic [15:0] div_i,
  output logic        tick_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        wrap;

  assign wrap   = (cnt_q == div_i);
  assign tick_o = en_i & wrap & ~restart_i;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART serial receive engine. Synchronises rxd, oversamples it, deframes
// start / 8 data (LSB first) / optional parity / stop, and presents each byte
// in a one-entry holding register with valid/ready handshake.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   baud_div_i             oversample tick every baud_div_i+1 clocks
//   rx_en_i                receiver enable; dropping it aborts a frame
//   parity_en_i            parity bit present after data
//   parity_even_i          1 = even, 0 = odd parity
//   rxd_i                  asynchronous serial input, idle high
//   rx_data_o, rx_valid_o  holding register and its valid flag
//   rx_ready_i             consumer pops the held byte
//   parity_err_o, frame_err_o, overrun_err_o  sticky error flags
//   err_clr_i              clears all sticky errors (a same-cycle set wins)
//   busy_o                 FSM outside idle
module uart_rx_core
  import uart_pkg::*;
#(
  // Ticks per bit; power of two >= 8.
  parameter int unsigned Oversample = 16,
  // Synchroniser depth; >= 2.
  parameter int unsigned SyncStages = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] baud_div_i,
  input  logic        rx_en_i,
  input  logic        parity_en_i,
  input  logic        parity_even_i,
  input  logic        rxd_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        overrun_err_o,
  input  logic        err_clr_i,
  output logic        busy_o
);

  localparam int unsigned SubW = $clog2(Oversample);
  // Majority vote over the three ticks around mid-bit; decision on the last.
  localparam logic [SubW-1:0] SubVoteA  = SubW'(Oversample / 2 - 1);
  localparam logic [SubW-1:0] SubVoteB  = SubW'(Oversample / 2);
  localparam logic [SubW-1:0] SubDecide = SubW'(Oversample / 2 + 1);
  localparam logic [SubW-1:0] SubLast   = SubW'(Oversample - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ---------------------------------------------------------------------------
  logic [SyncStages-1:0] sync_q;
  logic                  rxd_s;
  logic                  rxd_prev_q;
  logic                  fall;

  assign rxd_s = sync_q[SyncStages-1];
  assign fall  = rxd_prev_q & ~rxd_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '1;
      rxd_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SyncStages-2:0], rxd_i};
      rxd_prev_q <= rxd_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame configuration, latched as the frame starts
  // ---------------------------------------------------------------------------
  logic [15:0] div_q;
  logic        par_en_q, par_even_q;
  logic        cfg_load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
    end else if (cfg_load) begin
      div_q      <= baud_div_i;
      par_en_q   <= parity_en_i;
      par_even_q <= parity_even_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick generator; held at 0 in idle so ticks are phased to the start edge
  // ---------------------------------------------------------------------------
  rx_state_e state_q, state_d;
  logic      tick;

  uart_baud_tick u_baud_tick (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (rx_en_i),
    .restart_i (state_q == StIdle),
    .div_i     (div_q),
    .tick_o    (tick)
  );

  // ---------------------------------------------------------------------------
  // Deframing FSM
  // ---------------------------------------------------------------------------
  logic [SubW-1:0] sub_q, sub_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic            vote, at_decide, at_last;
  logic            load, par_set, frm_set;

  assign vote      = maj3(samp_a_q, samp_b_q, rxd_s);
  assign at_decide = tick & (sub_q == SubDecide);
  assign at_last   = tick & (sub_q == SubLast);

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    samp_a_d = samp_a_q;
    samp_b_d = samp_b_q;
    cfg_load = 1'b0;
    load     = 1'b0;
    par_set  = 1'b0;
    frm_set  = 1'b0;

    if ((state_q != StIdle) && tick) begin
      sub_d = sub_q + 1'b1;
      if (sub_q == SubVoteA) samp_a_d = rxd_s;
      if (sub_q == SubVoteB) samp_b_d = rxd_s;
    end

    unique case (state_q)
      StIdle: begin
        sub_d = '0;
        bit_d = '0;
        if (rx_en_i && fall) begin
          state_d  = StStart;
          cfg_load = 1'b1;
        end
      end
      StStart: begin
        // A start bit that votes high was a glitch.
        if (at_decide && vote) begin
          state_d = StIdle;
        end else if (at_last) begin
          state_d = StData;
        end
      end
      StData: begin
        if (at_decide) begin
          shift_d = {vote, shift_q[7:1]};
        end
        if (at_last) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = par_en_q ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (at_decide) begin
          par_set = (vote != parity_bit(shift_q, par_even_q));
        end
        if (at_last) begin
          state_d = StStop;
        end
      end
      StStop: begin
        // Deliver at mid-stop so back-to-back frames are not missed.
        if (at_decide) begin
          load = 1'b1;
          if (!vote) begin
            frm_set = 1'b1;
            state_d = StBreak;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StBreak: begin
        if (rxd_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Disable aborts the frame without touching flags or the holding register.
    if (!rx_en_i && (state_q != StIdle)) begin
      state_d = StIdle;
      load    = 1'b0;
      par_set = 1'b0;
      frm_set = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      sub_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      samp_a_q <= samp_a_d;
      samp_b_q <= samp_b_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register and sticky errors
  // ---------------------------------------------------------------------------
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       par_err_q, par_err_d;
  logic       frm_err_q, frm_err_d;
  logic       ovr_err_q, ovr_err_d;
  logic       pop, ovr_set;

  assign pop = rx_valid_q & rx_ready_i;

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovr_set    = 1'b0;
    if (pop) begin
      rx_valid_d = 1'b0;
    end
    if (load) begin
      // A pop in the same cycle frees the slot for the new byte.
      if (!rx_valid_q || pop) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    par_err_d = par_set | (par_err_q & ~err_clr_i);
    frm_err_d = frm_set | (frm_err_q & ~err_clr_i);
    ovr_err_d = ovr_set | (ovr_err_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_err_q  <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      ovr_err_q  <= ovr_err_d;
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign parity_err_o  = par_err_q;
  assign frame_err_o   = frm_err_q;
  assign overrun_err_o = ovr_err_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: serial frames are generated bit by bit,
// expected bytes are queued as frames are sent and compared when read out.
module tb_uart_rx_core;
  import uart_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] baud_div_i;
  logic        rx_en_i, parity_en_i, parity_even_i, rxd_i;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o, rx_ready_i;
  logic        parity_err_o, frame_err_o, overrun_err_o;
  logic        err_clr_i, busy_o;

  always #5 clk_i = ~clk_i;

  uart_rx_core dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .baud_div_i    (baud_div_i),
    .rx_en_i       (rx_en_i),
    .parity_en_i   (parity_en_i),
    .parity_even_i (parity_even_i),
    .rxd_i         (rxd_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .parity_err_o  (parity_err_o),
    .frame_err_o   (frame_err_o),
    .overrun_err_o (overrun_err_o),
    .err_clr_i     (err_clr_i),
    .busy_o        (busy_o)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cpb;
  logic [7:0] sbq[$];

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_div(input logic [15:0] d);
    baud_div_i = d;
    cpb = (int'(d) + 1) * 16;
  endtask

  // Drives one frame. low_stop replaces the stop bit by that many low bit
  // times; tail adds stop + one idle bit. rx_ready pulses on cycle pop_at.
  // lat returns the cycle at which rx_valid rose (-1 if it did not).
  task automatic send_frame(input logic [7:0] b, input bit par, input bit par_bad,
                            input int low_stop, input bit tail, input int pop_at,
                            output int lat);
    logic [31:0] frm;
    logic        vprev;
    int          n;
    frm = '1;
    n = 0;
    frm[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin
      frm[n] = b[i]; n++;
    end
    if (par) begin
      frm[n] = (parity_even_i ? (^b) : (~^b)) ^ par_bad; n++;
    end
    for (int i = 0; i < low_stop; i++) begin
      frm[n] = 1'b0; n++;
    end
    if (tail) n += 2;
    lat = -1;
    vprev = rx_valid_o;
    for (int c = 0; c < n * cpb; c++) begin
      @(negedge clk_i);
      if (lat < 0 && rx_valid_o && !vprev) lat = c;
      vprev = rx_valid_o;
      rxd_i = frm[c / cpb];
      rx_ready_i = (c == pop_at);
    end
    rx_ready_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] exp;
    vectors++;
    assert (sbq.size() != 0) else begin
      miscompares++;
      $error("FAIL %s_sbq: observed empty queue expected entry", tag);
    end
    exp = (sbq.size() != 0) ? sbq.pop_front() : 8'h00;
    chk({tag, "_valid"}, rx_valid_o, 1);
    chk({tag, "_data"}, rx_data_o, exp);
    @(negedge clk_i) rx_ready_i = 1'b1;
    @(negedge clk_i) rx_ready_i = 1'b0;
    chk({tag, "_popped"}, rx_valid_o, 0);
  endtask

  task automatic err_clear();
    @(negedge clk_i) err_clr_i = 1'b1;
    @(negedge clk_i) err_clr_i = 1'b0;
  endtask

  initial begin
    int  lat, lat1;
    bit  saw;
    logic [7:0] b;

    rst_ni = 1'b0; rxd_i = 1'b1; rx_en_i = 1'b0; rx_ready_i = 1'b0; err_clr_i = 1'b0;
    parity_en_i = 1'b0; parity_even_i = 1'b0;
    set_div(Baud16M115200);
    #1;
    chk("rst_valid", rx_valid_o, 0);
    chk("rst_data", rx_data_o, 0);
    chk("rst_perr", parity_err_o, 0);
    chk("rst_ferr", frame_err_o, 0);
    chk("rst_oerr", overrun_err_o, 0);
    chk("rst_busy", busy_o, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    rx_en_i = 1'b1;
    repeat (5) @(negedge clk_i);

    // Basic byte, parity off, 144 clocks/bit
    sbq.push_back(8'hA5);
    send_frame(8'hA5, 0, 0, 0, 1, -1, lat);
    chk("a5_lat_range", (lat >= 9 * cpb) && (lat <= 10 * cpb), 1);
    chk("a5_perr", parity_err_o, 0);
    chk("a5_ferr", frame_err_o, 0);
    chk("a5_oerr", overrun_err_o, 0);
    pop_chk("a5");

    // Wrong even parity, then clear
    parity_en_i = 1'b1; parity_even_i = 1'b1;
    sbq.push_back(8'h07);
    send_frame(8'h07, 1, 1, 0, 1, -1, lat);
    chk("par_err_set", parity_err_o, 1);
    chk("par_ferr", frame_err_o, 0);
    pop_chk("par07");
    err_clear();
    chk("par_err_clr", parity_err_o, 0);

    // Correct odd parity
    parity_even_i = 1'b0;
    sbq.push_back(8'h07);
    send_frame(8'h07, 1, 0, 0, 1, -1, lat);
    chk("odd_ok_perr", parity_err_o, 0);
    pop_chk("odd07");

    // Stop bit held low for 3 bit times
    parity_en_i = 1'b0;
    sbq.push_back(8'h3C);
    send_frame(8'h3C, 0, 0, 3, 0, -1, lat);
    chk("brk_ferr", frame_err_o, 1);
    chk("brk_busy", busy_o, 1);
    @(negedge clk_i) rxd_i = 1'b1;
    for (int i = 0; i < 10 && busy_o; i++) @(negedge clk_i);
    chk("brk_exit", busy_o, 0);
    pop_chk("brk3c");
    err_clear();
    chk("brk_ferr_clr", frame_err_o, 0);
    sbq.push_back(8'h55);
    send_frame(8'h55, 0, 0, 0, 1, -1, lat);
    chk("after_brk_ferr", frame_err_o, 0);
    pop_chk("b55");

    // Overrun: second byte dropped
    sbq.push_back(8'h11);
    send_frame(8'h11, 0, 0, 0, 1, -1, lat);
    send_frame(8'h22, 0, 0, 0, 1, -1, lat);
    chk("ovr_set", overrun_err_o, 1);
    pop_chk("ovr_keep11");
    err_clear();
    chk("ovr_clr", overrun_err_o, 0);

    // Pop coinciding with the load of the second byte
    send_frame(8'h11, 0, 0, 0, 1, -1, lat1);
    chk("coin_first_valid", rx_valid_o, 1);
    chk("coin_first_data", rx_data_o, 8'h11);
    sbq.push_back(8'h22);
    send_frame(8'h22, 0, 0, 0, 1, lat1 - 1, lat);
    chk("coin_oerr", overrun_err_o, 0);
    pop_chk("coin22");

    // Short glitch on idle line
    @(negedge clk_i) rxd_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rxd_i = 1'b1;
    saw = 0;
    for (int c = 0; c < cpb; c++) begin
      @(negedge clk_i);
      if (busy_o) saw = 1;
    end
    chk("glitch_seen", saw, 1);
    chk("glitch_busy", busy_o, 0);
    chk("glitch_valid", rx_valid_o, 0);

    // Reset in the middle of a frame, with flags and an unread byte pending
    parity_en_i = 1'b1; parity_even_i = 1'b1;
    send_frame(8'h01, 1, 1, 0, 1, -1, lat);
    chk("pre_rst_valid", rx_valid_o, 1);
    chk("pre_rst_perr", parity_err_o, 1);
    for (int c = 0; c < 3 * cpb + cpb / 2; c++) begin
      @(negedge clk_i) rxd_i = 1'b0;  // start + low nibble of 0xF0
    end
    chk("pre_rst_busy", busy_o, 1);
    @(negedge clk_i) rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", rx_valid_o, 0);
    chk("mid_rst_data", rx_data_o, 0);
    chk("mid_rst_perr", parity_err_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    rxd_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (cpb) @(negedge clk_i);
    sbq.push_back(8'h5A);
    send_frame(8'h5A, 1, 0, 0, 1, -1, lat);
    chk("post_rst_perr", parity_err_o, 0);
    pop_chk("rst5a");

    // Burst at a faster divisor with even parity
    set_div(16'd3);
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      sbq.push_back(b);
      send_frame(b, 1, 0, 0, 1, -1, lat);
      pop_chk("burst");
    end
    chk("burst_perr", parity_err_o, 0);
    chk("burst_ferr", frame_err_o, 0);
    chk("burst_oerr", overrun_err_o, 0);

    // baud_div = 0: a tick every clock
    set_div(16'd0);
    parity_en_i = 1'b0;
    sbq.push_back(8'hC3);
    send_frame(8'hC3, 0, 0, 0, 1, -1, lat);
    pop_chk("div0");
    chk("div0_ferr", frame_err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
